// File: rtl/agc_timing_pkg.sv
// Shared types, constants and helpers for the AGC timepulse generator.
package agc_timing_pkg;

  typedef enum logic [1:0] {
    RUN,
    STOPPED,
    STEP
  } tp_state_t;

  localparam int unsigned TP_FIRST   = 1;
  localparam int unsigned TP_LAST    = 12;
  localparam int unsigned MAX_RING_W = 16;

  // Rotate a one-hot value left by one within the low 'width' bits.
  function automatic logic [MAX_RING_W-1:0] onehot_rotl(input logic [MAX_RING_W-1:0] v,
                                                       input int unsigned width);
    logic [MAX_RING_W-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_RING_W; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return ((v << 1) | (v >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/agc_ring_counter.sv
// One-hot ring counter; clr restarts at bit 0 when enabled, or empties the ring when not.
module agc_ring_counter
  import agc_timing_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] FIRST = WIDTH'(1);

  logic [MAX_RING_W-1:0] q_ext;
  logic [MAX_RING_W-1:0] rot;

  always_comb begin
    q_ext = '0;
    q_ext[WIDTH-1:0] = q;
    rot = onehot_rotl(q_ext, WIDTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= FIRST;
    end else if (clr) begin
      q <= en ? FIRST : '0;
    end else if (en) begin
      q <= rot[WIDTH-1:0];
    end
  end

  // Advancing out of the top bit on this edge.
  assign wrap = en && !clr && q[WIDTH-1];

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC memory-cycle timing: one-hot timepulses T01..T12, each split into one-hot phases,
// with stop-at-cycle-end and single-cycle stepping. All outputs are registered.
module agc_timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int unsigned NUM_TP  = TP_LAST,
  parameter int unsigned NUM_PHS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gojam,
  input  logic               stop_req,
  input  logic               step,
  output logic [NUM_TP-1:0]  tp,
  output logic [NUM_PHS-1:0] phs,
  output logic [3:0]         tp_num,
  output logic               mct,
  output logic               stopped
);

  if (NUM_TP < 1 || NUM_TP > 15) begin : g_num_tp_check
    $error("NUM_TP must be in 1..15 to fit the 4-bit tp_num");
  end
  if (NUM_PHS < 2 || NUM_PHS > MAX_RING_W) begin : g_num_phs_check
    $error("NUM_PHS must be in 2..16");
  end

  localparam logic [3:0] TP_NUM_FIRST = 4'(TP_FIRST);
  localparam logic [3:0] TP_NUM_LAST  = 4'(NUM_TP);

  tp_state_t  state_q, state_d;
  logic       restart;
  logic       live;
  logic       phs_wrap;
  logic       tp_wrap;
  logic       tp_en;
  logic [3:0] tp_num_q, tp_num_d;
  logic       mct_q, mct_d;
  logic       stopped_q;

  // Stop requests are only honoured on the registered mct cycle.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (gojam) begin
      state_d = RUN;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        RUN, STEP: begin
          if (mct_q) begin
            if (stop_req) begin
              state_d = STOPPED;
              restart = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        STOPPED: begin
          if (!stop_req) begin
            state_d = RUN;
            restart = 1'b1;
          end else if (step) begin
            state_d = STEP;
            restart = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          restart = 1'b1;
        end
      endcase
    end
  end

  assign live  = (state_d != STOPPED);
  assign tp_en = restart ? live : phs_wrap;

  agc_ring_counter #(
    .WIDTH(NUM_PHS)
  ) u_phs_ring (
    .clk (clk),
    .rst (rst),
    .en  (live),
    .clr (restart),
    .q   (phs),
    .wrap(phs_wrap)
  );

  agc_ring_counter #(
    .WIDTH(NUM_TP)
  ) u_tp_ring (
    .clk (clk),
    .rst (rst),
    .en  (tp_en),
    .clr (restart),
    .q   (tp),
    .wrap(tp_wrap)
  );

  always_comb begin
    tp_num_d = tp_num_q;
    if (restart) begin
      tp_num_d = live ? TP_NUM_FIRST : 4'd0;
    end else if (tp_en) begin
      tp_num_d = tp_wrap ? TP_NUM_FIRST : tp_num_q + 4'd1;
    end
    // Next edge lands on the last phase of the last timepulse.
    mct_d = live && !restart && tp[NUM_TP-1] && phs[NUM_PHS-2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      tp_num_q  <= TP_NUM_FIRST;
      mct_q     <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tp_num_q  <= tp_num_d;
      mct_q     <= mct_d;
      stopped_q <= !live;
    end
  end

  assign tp_num  = tp_num_q;
  assign mct     = mct_q;
  assign stopped = stopped_q;

  // Sanity checks on TP_NUM_LAST consistency are implicit: the tp ring wrap drives tp_num.
  logic unused_last;
  assign unused_last = ^TP_NUM_LAST;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Scoreboard bench for agc_timepulse_gen: cycle-position reference model, random and
// directed stimulus, monitor comparing every cycle on the falling edge.
`timescale 1ns / 1ps
module tb_agc_timepulse_gen;

  localparam int NTP = 12;
  localparam int NPH = 4;
  localparam int CYC = NTP * NPH;

  typedef struct packed {
    logic [NTP-1:0] tp;
    logic [NPH-1:0] phs;
    logic [3:0]     tp_num;
    logic           mct;
    logic           stopped;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           gojam;
  logic           stop_req;
  logic           step;
  logic [NTP-1:0] tp;
  logic [NPH-1:0] phs;
  logic [3:0]     tp_num;
  logic           mct;
  logic           stopped;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  bit   mon_en = 0;
  bit   rst_chk = 0;
  event rst_chk_ev;

  // Reference model state: position within the memory cycle, and halted flag.
  int pos;
  bit mstop;

  agc_timepulse_gen #(
    .NUM_TP (NTP),
    .NUM_PHS(NPH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gojam   (gojam),
    .stop_req(stop_req),
    .step    (step),
    .tp      (tp),
    .phs     (phs),
    .tp_num  (tp_num),
    .mct     (mct),
    .stopped (stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model_out();
    exp_t e;
    e.stopped = mstop;
    e.tp      = mstop ? '0 : NTP'(1) << (pos / NPH);
    e.phs     = mstop ? '0 : NPH'(1) << (pos % NPH);
    e.tp_num  = mstop ? 4'd0 : 4'(pos / NPH + 1);
    e.mct     = !mstop && (pos == CYC - 1);
    return e;
  endfunction

  task automatic model_step(input bit gj, input bit sr, input bit st);
    if (gj) begin
      pos = 0;
      mstop = 0;
    end else if (mstop) begin
      if (!sr || st) begin
        mstop = 0;
        pos = 0;
      end
    end else if (pos == CYC - 1 && sr) begin
      mstop = 1;
    end else begin
      pos = (pos + 1) % CYC;
    end
  endtask

  // Called just after a rising edge: set inputs for the next edge and predict its result.
  task automatic cycle(input bit gj, input bit sr, input bit st);
    gojam = gj;
    stop_req = sr;
    step = st;
    model_step(gj, sr, st);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2;
    mon_en = 0;
    sb.delete();
    rst = 1'b0;
    #0.5;
    rst_chk = 1;
    ->rst_chk_ev;
    #0.5;
    rst_chk = 0;
    @(posedge clk);
    #1;
    gojam = 0;
    stop_req = 0;
    step = 0;
    rst = 1'b1;
    pos = 0;
    mstop = 0;
    sb.push_back(model_out());
    mon_en = 1;
  endtask

  always @(negedge clk or rst_chk_ev) begin
    if (rst_chk) begin
      total++;
      if (tp !== NTP'(1) || phs !== NPH'(1) || tp_num !== 4'd1 || mct !== 1'b0 ||
          stopped !== 1'b0) begin
        bad++;
        $display("FAIL async_reset @%0t: got tp=%h phs=%h tp_num=%0d mct=%b stopped=%b, want tp=001 phs=1 tp_num=1 mct=0 stopped=0",
                 $time, tp, phs, tp_num, mct, stopped);
      end
    end else if (mon_en) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow @%0t: no expected entry queued", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (tp !== e.tp || phs !== e.phs || tp_num !== e.tp_num || mct !== e.mct ||
            stopped !== e.stopped) begin
          bad++;
          $display("FAIL cycle_check @%0t: got tp=%h phs=%h tp_num=%0d mct=%b stopped=%b, want tp=%h phs=%h tp_num=%0d mct=%b stopped=%b",
                   $time, tp, phs, tp_num, mct, stopped, e.tp, e.phs, e.tp_num, e.mct,
                   e.stopped);
        end
      end
    end
  end

  initial begin
    bit sr_lvl;
    rst = 1'b0;
    gojam = 0;
    stop_req = 0;
    step = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    pos = 0;
    mstop = 0;
    sb.push_back(model_out());
    mon_en = 1;

    // Free run for two full memory cycles.
    repeat (2 * CYC) cycle(0, 0, 0);

    // Stop requested mid-cycle and held: halts at end of cycle.
    repeat (10) cycle(0, 0, 0);
    repeat (50) cycle(0, 1, 0);

    // Single step while halted, stop still requested.
    cycle(0, 1, 1);
    repeat (60) cycle(0, 1, 0);

    // Release the stop, then a stop pulse that drops before mct.
    repeat (5) cycle(0, 0, 0);
    for (int i = 0; i < 2 * CYC && pos != 10; i++) cycle(0, 0, 0);
    repeat (10) cycle(0, 1, 0);
    repeat (60) cycle(0, 0, 0);

    // Step held high with stop held: back-to-back stepped cycles.
    repeat (50) cycle(0, 1, 0);
    repeat (110) cycle(0, 1, 1);
    repeat (5) cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);

    // gojam at T07 phase 2.
    for (int i = 0; i < 2 * CYC && pos != 26; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (60) cycle(0, 0, 0);

    // gojam while halted, and gojam held.
    repeat (50) cycle(0, 1, 0);
    repeat (3) cycle(1, 1, 0);
    repeat (10) cycle(0, 0, 0);

    // Asynchronous reset mid-T05, then while halted.
    for (int i = 0; i < 2 * CYC && pos != 17; i++) cycle(0, 0, 0);
    async_reset();
    repeat (5) cycle(0, 0, 0);
    for (int i = 0; i < 3 * CYC && !mstop; i++) cycle(0, 1, 0);
    cycle(0, 1, 0);
    async_reset();
    repeat (10) cycle(0, 0, 0);

    // Randomised traffic.
    sr_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) sr_lvl = !sr_lvl;
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 79) == 0, sr_lvl, $urandom_range(0, 2) == 0);
      end
    end

    @(negedge clk);
    #1;
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agc_timepulse_gen.md
Name: agc_timepulse_gen

Overview:
Generates the AGC memory-cycle timing: twelve one-hot timepulses (T01..T12), each split into one-hot clock phases. Sits directly upstream of the NOR-gate logic boards (quad-NOR packages) and drives their timing inputs. Registered outputs only, so downstream NOR nets never see decode glitches. Supports monitor stop-at-cycle-end and single-cycle stepping.

Parameters:
NUM_TP, 12, timepulses per memory cycle.
NUM_PHS, 4, clock phases per timepulse.

Ports:
clk  input  1  master clock; every transition occurs on the rising edge.
rst  input  1  asynchronous reset, active-low.
gojam  input  1  synchronous restart; when high, forces the cycle back to T01/phase 0 on the next edge.
stop_req  input  1  request to halt at the end of the current memory cycle.
step  input  1  single-cycle advance request; honoured only while stopped.
tp  output  NUM_TP  one-hot timepulse; bit 0 is T01.
phs  output  NUM_PHS  one-hot phase within the current timepulse.
tp_num  output  4  binary timepulse number, 1..12; 0 while stopped.
mct  output  1  one-clock pulse on the last phase of T12 (memory cycle complete).
stopped  output  1  high while halted.

Behaviour:
- Reset (rst low, asynchronous): tp = 1 (T01), phs = 1, tp_num = 1, mct = 0, stopped = 0. The state machine is RUN.
- State machine states: RUN, STOPPED, STEP.
- RUN:
  - phs rotates left every clock.
  - When phs wraps from the last phase to bit 0, tp rotates left and tp_num increments.
  - From T12 the block wraps to T01, and tp_num goes from 12 to 1.
- mct is registered. It is high exactly during the cycle where tp = T12 and phs = last phase.
- Stop handshake:
  - stop_req is sampled only on the mct cycle.
  - If stop_req is high on that cycle, the next state is STOPPED.
  - On entry to STOPPED: tp = 0, phs = 0, tp_num = 0, stopped = 1.
- STOPPED exit:
  - If stop_req is low: return to RUN at T01/phase 0 on the next edge, and stopped falls on that same edge.
  - Else, if step is high: go to STEP at T01/phase 0, with stopped = 0.
  - step is level-sampled. A step held high performs back-to-back cycles, one per sampled edge in STOPPED.
- STEP:
  - Behaves exactly like RUN for one full memory cycle, NUM_TP*NUM_PHS clocks.
  - At its mct cycle it returns to STOPPED when stop_req is high, otherwise to RUN.
- gojam:
  - Has priority over everything except rst.
  - From any state, the next edge gives tp = T01, phs = bit 0, tp_num = 1, mct = 0, stopped = 0, state RUN.
  - A pending stop is discarded.
  - gojam held high keeps the block at T01/phase 0.
- Invariants:
  - Outside STOPPED, exactly one bit of tp and exactly one bit of phs is set.
  - In STOPPED, both tp and phs are zero.
- Timing:
  - Cycle length is NUM_TP*NUM_PHS clocks (48 by default).
  - Latency from a stop_req sampled on mct to stopped = 1 is one clock.
- stop_req asserted mid-cycle and then dropped before mct has no effect.
- tp_num width is fixed at 4; NUM_TP must be at most 15 (elaboration check).

Decomposition:
- Package agc_timing_pkg holds:
  - state enum tp_state_t {RUN, STOPPED, STEP};
  - localparams TP_FIRST = 1 and TP_LAST = 12;
  - the function onehot_rotl.
- Sub-module agc_ring_counter(clk, rst, en, clr, q, wrap), parameterised by WIDTH.
  - Instantiate it twice.
  - The phase ring is enabled whenever the block is not stopped.
  - The timepulse ring is enabled on the phase ring's wrap.
  - The FSM and the mct/tp_num registers live in the top module.

Test Plan:
- Reset then free run for 96 clocks:
  - tp sequence 001h, 002h, … 800h, 001h, each value held for 4 clocks;
  - mct high exactly at clocks 47 and 95;
  - tp_num runs 1..12 and repeats.
- stop_req raised at clock 10 and held:
  - tp = 0, phs = 0 and stopped = 1 from clock 48;
  - tp_num = 0.
- stop_req pulsed at clock 10, low again at clock 20:
  - no stop occurs;
  - mct at clock 47 and the run continues.
- While stopped, step pulsed for one clock with stop_req held high:
  - exactly 48 clocks of sequencing with one mct;
  - then stopped = 1 again.
- gojam asserted at T07/phase 2 for 1 clock:
  - next edge gives tp = 001h, phs = 1h, tp_num = 1;
  - the following mct comes 47 clocks later.
- rst pulsed low asynchronously mid-T05, between clock edges:
  - outputs immediately become tp = 001h, phs = 1h, stopped = 0;
  - the same happens when rst is pulsed while STOPPED.
